// File: rtl/ds_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage scoreboard interlock controller.
// Holds the register-file geometry, the pending-counter sizing and the
// drain FSM state encodings used by ds_hazard_ctrl and its counter entries.
package ds_hazard_ctrl_pkg;

    localparam int NUM_GPR         = 32;
    localparam int SB_CNT_W        = 2;
    localparam int SB_MAX_INFLIGHT = 3;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_DRAIN = 2'd1,
        SB_ACK   = 2'd2
    } sb_state_e;

endpackage

// File: rtl/ds_hazard_ctrl_sb_entry.sv
// One scoreboard entry: a saturating up/down counter of in-flight writes to a
// single GPR. An issue and a retire in the same cycle cancel out. Attempts to
// count past MAX_INFLIGHT or below zero leave the count alone and pulse err.
module ds_hazard_ctrl_sb_entry
    import ds_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = SB_CNT_W,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic dec,
    output logic pending,
    output logic err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt;
    logic             overflow;
    logic             underflow;

    // Detect illegal transitions; a matched inc/dec pair is never an error
    always_comb begin
        overflow  = inc & ~dec & (cnt == CNT_MAX);
        underflow = dec & ~inc & (cnt == '0);
        err       = overflow | underflow;
        pending   = (cnt != '0);
    end

    // Count in-flight writes, holding the value on overflow or underflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (inc && !dec && !overflow) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !underflow) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ds_hazard_ctrl.sv
// Scoreboard interlock for the decode stage. Tracks GPR writes between issue
// from ID and writeback from WB, stalls decode on read-after-write hazards
// (the pipeline has no forwarding) and offers a drain handshake that waits for
// the scoreboard to empty. Defining DS_HAZARD_PERF_EN adds a saturating
// stall_cycles counter of hazard stalls.
module ds_hazard_ctrl #(
    parameter int NUM_GPR      = ds_hazard_ctrl_pkg::NUM_GPR,
    parameter int CNT_W        = ds_hazard_ctrl_pkg::SB_CNT_W,
    parameter int MAX_INFLIGHT = ds_hazard_ctrl_pkg::SB_MAX_INFLIGHT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_valid,
    input  logic        es_allowin,
    input  logic        ds_gr_we,
    input  logic [4:0]  ds_dest,
    input  logic [4:0]  ds_rj,
    input  logic [4:0]  ds_rkd,
    input  logic        ds_use_rj,
    input  logic        ds_use_rkd,
    input  logic        ws_valid,
    input  logic        ws_we,
    input  logic [4:0]  ws_waddr,
    input  logic        drain_req,
    output logic        ds_ready_go,
    output logic        drain_ack,
    output logic        sb_busy,
    output logic        sb_err
`ifdef DS_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    import ds_hazard_ctrl_pkg::*;

    logic [NUM_GPR-1:0] pending_vec;
    logic [NUM_GPR-1:0] err_vec;
    logic               issue;
    logic               retire;
    logic               hazard;
    logic               drain_block;
    sb_state_e          state_q;
    sb_state_e          state_d;

    assign pending_vec[0] = 1'b0;
    assign err_vec[0]     = 1'b0;

    // Qualify issue and retire events; r0 is hard-wired zero and never tracked
    always_comb begin
        issue  = ds_valid & ds_ready_go & es_allowin & ds_gr_we & (ds_dest != 5'd0);
        retire = ws_valid & ws_we & (ws_waddr != 5'd0);
    end

    generate
        for (genvar i = 1; i < NUM_GPR; i++) begin : g_entry
            ds_hazard_ctrl_sb_entry #(
                .CNT_W        (CNT_W),
                .MAX_INFLIGHT (MAX_INFLIGHT)
            ) u_entry (
                .clk     (clk),
                .resetn  (resetn),
                .inc     (issue  & (ds_dest  == 5'(i))),
                .dec     (retire & (ws_waddr == 5'(i))),
                .pending (pending_vec[i]),
                .err     (err_vec[i])
            );
        end
    endgenerate

    // Hazard uses registered counts only, so a same-cycle retire still stalls
    always_comb begin
        hazard = (ds_use_rj  & (ds_rj  != 5'd0) & pending_vec[ds_rj])
               | (ds_use_rkd & (ds_rkd != 5'd0) & pending_vec[ds_rkd]);
        sb_busy     = |pending_vec;
        ds_ready_go = ~hazard & ~drain_block;
    end

    // Drain FSM next state; issue is blocked only while drain_req is held
    always_comb begin
        state_d     = state_q;
        drain_block = 1'b0;
        drain_ack   = 1'b0;
        case (state_q)
            SB_IDLE: begin
                if (drain_req) state_d = SB_DRAIN;
            end
            SB_DRAIN: begin
                if (!drain_req) begin
                    state_d = SB_IDLE;
                end else begin
                    drain_block = 1'b1;
                    if (!sb_busy) begin
                        state_d   = SB_ACK;
                        drain_ack = 1'b1;
                    end
                end
            end
            SB_ACK: begin
                drain_ack = 1'b1;
                if (!drain_req) state_d = SB_IDLE;
                else            drain_block = 1'b1;
            end
            default: state_d = SB_IDLE;
        endcase
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= SB_IDLE;
        else         state_q <= state_d;
    end

    // Sticky error flag collecting any entry's overflow or underflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sb_err <= 1'b0;
        else         sb_err <= sb_err | (|err_vec);
    end

`ifdef DS_HAZARD_PERF_EN
    // Count hazard stalls of a valid decode slot, saturating instead of wrapping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (ds_valid && hazard && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ds_hazard_ctrl.sv
// Directed self-checking bench for ds_hazard_ctrl. Inputs change 1 ns after
// the rising edge and outputs are sampled 1 ns later, away from the edge.
module tb_ds_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ds_valid, es_allowin, ds_gr_we, ds_use_rj, ds_use_rkd;
    logic [4:0]  ds_dest, ds_rj, ds_rkd, ws_waddr;
    logic        ws_valid, ws_we, drain_req;
    logic        ds_ready_go, drain_ack, sb_busy, sb_err;
`ifdef DS_HAZARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    ds_hazard_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .ds_valid    (ds_valid),
        .es_allowin  (es_allowin),
        .ds_gr_we    (ds_gr_we),
        .ds_dest     (ds_dest),
        .ds_rj       (ds_rj),
        .ds_rkd      (ds_rkd),
        .ds_use_rj   (ds_use_rj),
        .ds_use_rkd  (ds_use_rkd),
        .ws_valid    (ws_valid),
        .ws_we       (ws_we),
        .ws_waddr    (ws_waddr),
        .drain_req   (drain_req),
        .ds_ready_go (ds_ready_go),
        .drain_ack   (drain_ack),
        .sb_busy     (sb_busy),
        .sb_err      (sb_err)
`ifdef DS_HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ds_valid = 0; es_allowin = 1; ds_gr_we = 0; ds_dest = 0;
        ds_rj = 0; ds_rkd = 0; ds_use_rj = 0; ds_use_rkd = 0;
        ws_valid = 0; ws_we = 0; ws_waddr = 0; drain_req = 0;
    endtask

    task automatic decode(input logic v, input logic we, input logic [4:0] d,
                          input logic urj, input logic [4:0] rj,
                          input logic urk, input logic [4:0] rk);
        ds_valid = v; ds_gr_we = we; ds_dest = d;
        ds_use_rj = urj; ds_rj = rj; ds_use_rkd = urk; ds_rkd = rk;
    endtask

    task automatic wb(input logic v, input logic [4:0] a);
        ws_valid = v; ws_we = v; ws_waddr = a;
    endtask

    task automatic pulse_reset();
        resetn = 0;
        #3;
        resetn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        #2;
        checks++; if (ds_ready_go !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_go: got %b want 1", ds_ready_go); end
        checks++; if (drain_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_drain_ack: got %b want 0", drain_ack); end
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_sb_busy: got %b want 0", sb_busy); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_sb_err: got %b want 0", sb_err); end
        tick();
        resetn = 1;
    endtask

    task automatic test_back_to_back();
        int stalls;
        // producer add.w r5 issues
        tick(); decode(1, 1, 5'd5, 0, 0, 0, 0); #1;
        checks++; if (ds_ready_go !== 1'b1) begin failures++; $display("[TB] FAIL b2b_producer_issue: got %b want 1", ds_ready_go); end
        // dependent add.w r6,r5,r5 in the next slot; producer WB in the 3rd stall
        stalls = 0;
        tick(); decode(1, 1, 5'd6, 1, 5'd5, 1, 5'd5); #1;
        checks++; if (sb_busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy: got %b want 1", sb_busy); end
        if (!ds_ready_go) stalls++;
        tick(); #1; if (!ds_ready_go) stalls++;
        tick(); wb(1, 5'd5); #1;
        checks++; if (ds_ready_go !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stall_on_retire: got %b want 0", ds_ready_go); end
        if (!ds_ready_go) stalls++;
        tick(); wb(0, 5'd0); #1;
        checks++; if (ds_ready_go !== 1'b1) begin failures++; $display("[TB] FAIL b2b_release: got %b want 1", ds_ready_go); end
        checks++; if (stalls != 3) begin failures++; $display("[TB] FAIL b2b_stall_count: got %0d want 3", stalls); end
        // r6 now issued; retire it to leave the scoreboard empty
        tick(); decode(0, 0, 0, 0, 0, 0, 0); wb(1, 5'd6);
        tick(); wb(0, 0); #1;
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty: got %b want 0", sb_busy); end
        // dependent two slots later stalls twice
        stalls = 0;
        decode(1, 1, 5'd8, 0, 0, 0, 0);
        tick(); decode(0, 0, 0, 0, 0, 0, 0);
        tick(); decode(1, 0, 0, 1, 5'd8, 0, 0); #1; if (!ds_ready_go) stalls++;
        tick(); wb(1, 5'd8); #1; if (!ds_ready_go) stalls++;
        tick(); wb(0, 0); #1; if (!ds_ready_go) stalls++;
        checks++; if (stalls != 2) begin failures++; $display("[TB] FAIL two_slot_stall_count: got %0d want 2", stalls); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("[TB] FAIL b2b_sb_err: got %b want 0", sb_err); end
        decode(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_same_cycle();
        tick(); decode(1, 1, 5'd7, 0, 0, 0, 0);
        // second write to r7 issues while the first retires
        tick(); wb(1, 5'd7);
        tick(); wb(0, 0); decode(1, 0, 0, 1, 5'd7, 0, 0); #1;
        checks++; if (ds_ready_go !== 1'b0) begin failures++; $display("[TB] FAIL same_cycle_hazard: got %b want 0", ds_ready_go); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("[TB] FAIL same_cycle_sb_err: got %b want 0", sb_err); end
        tick(); wb(1, 5'd7);
        tick(); wb(0, 0); #1;
        checks++; if (ds_ready_go !== 1'b1) begin failures++; $display("[TB] FAIL same_cycle_release: got %b want 1", ds_ready_go); end
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL same_cycle_empty: got %b want 0", sb_busy); end
        decode(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_r0();
        tick(); decode(1, 1, 5'd0, 0, 0, 0, 0); wb(1, 5'd0);
        tick(); wb(0, 0); decode(1, 0, 0, 1, 5'd0, 1, 5'd0); #1;
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL r0_busy: got %b want 0", sb_busy); end
        checks++; if (ds_ready_go !== 1'b1) begin failures++; $display("[TB] FAIL r0_ready_go: got %b want 1", ds_ready_go); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("[TB] FAIL r0_sb_err: got %b want 0", sb_err); end
        decode(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_drain();
        tick(); decode(1, 1, 5'd10, 0, 0, 0, 0);
        tick(); decode(1, 1, 5'd11, 0, 0, 0, 0);
        tick(); decode(0, 0, 0, 0, 0, 0, 0); drain_req = 1;
        // DRAIN: a valid writer in decode must not issue
        tick(); decode(1, 1, 5'd12, 0, 0, 0, 0); wb(1, 5'd10); #1;
        checks++; if (ds_ready_go !== 1'b0) begin failures++; $display("[TB] FAIL drain_blocks_issue: got %b want 0", ds_ready_go); end
        checks++; if (drain_ack !== 1'b0) begin failures++; $display("[TB] FAIL drain_early_ack: got %b want 0", drain_ack); end
        tick(); wb(1, 5'd11); #1;
        checks++; if (drain_ack !== 1'b0) begin failures++; $display("[TB] FAIL drain_ack_busy: got %b want 0", drain_ack); end
        tick(); wb(0, 0); #1;
        checks++; if (drain_ack !== 1'b1) begin failures++; $display("[TB] FAIL drain_ack_after_retire: got %b want 1", drain_ack); end
        tick(); #1;
        checks++; if (drain_ack !== 1'b1) begin failures++; $display("[TB] FAIL drain_ack_hold: got %b want 1", drain_ack); end
        checks++; if (ds_ready_go !== 1'b0) begin failures++; $display("[TB] FAIL drain_ack_blocks: got %b want 0", ds_ready_go); end
        drain_req = 0; #1;
        checks++; if (ds_ready_go !== 1'b1) begin failures++; $display("[TB] FAIL drain_release_same_cycle: got %b want 1", ds_ready_go); end
        // r12 issues at this edge
        tick(); decode(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (drain_ack !== 1'b0) begin failures++; $display("[TB] FAIL drain_ack_cleared: got %b want 0", drain_ack); end
        checks++; if (sb_busy !== 1'b1) begin failures++; $display("[TB] FAIL drain_post_issue: got %b want 1", sb_busy); end
        wb(1, 5'd12);
        tick(); wb(0, 0); #1;
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL drain_final_empty: got %b want 0", sb_busy); end
    endtask

    task automatic test_overflow_underflow();
        tick(); decode(1, 1, 5'd3, 0, 0, 0, 0);
        tick(); tick(); tick();
        tick(); decode(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (sb_err !== 1'b1) begin failures++; $display("[TB] FAIL overflow_err: got %b want 1", sb_err); end
        // count held at 3: two retires leave it busy, the third empties it
        wb(1, 5'd3); tick(); tick(); #1;
        checks++; if (sb_busy !== 1'b1) begin failures++; $display("[TB] FAIL overflow_held: got %b want 1", sb_busy); end
        tick(); wb(0, 0); #1;
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL overflow_drained: got %b want 0", sb_busy); end
        pulse_reset();
        tick(); wb(1, 5'd9);
        tick(); wb(0, 0); #1;
        checks++; if (sb_err !== 1'b1) begin failures++; $display("[TB] FAIL underflow_err: got %b want 1", sb_err); end
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL underflow_held_zero: got %b want 0", sb_busy); end
        // counter stayed at 0: one issue then one retire empties r9
        decode(1, 1, 5'd9, 0, 0, 0, 0);
        tick(); decode(0, 0, 0, 0, 0, 0, 0); wb(1, 5'd9);
        tick(); wb(0, 0); #1;
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL underflow_no_wrap: got %b want 0", sb_busy); end
    endtask

`ifdef DS_HAZARD_PERF_EN
    task automatic test_perf();
        pulse_reset();
        tick(); decode(1, 1, 5'd13, 0, 0, 0, 0);
        tick(); decode(1, 0, 0, 1, 5'd13, 0, 0);
        tick();
        tick(); wb(1, 5'd13);
        tick(); wb(0, 0); decode(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (stall_cycles !== 32'd3) begin failures++; $display("[TB] FAIL perf_stall_cycles: got %0d want 3", stall_cycles); end
    endtask
`endif

    task automatic test_async_reset();
        tick(); decode(1, 1, 5'd4, 0, 0, 0, 0);
        tick();
        tick(); decode(1, 0, 0, 1, 5'd4, 0, 0); #1;
        checks++; if (ds_ready_go !== 1'b0) begin failures++; $display("[TB] FAIL async_pre_stall: got %b want 0", ds_ready_go); end
        #1;
        resetn = 0;
        #1;
        checks++; if (sb_busy !== 1'b0) begin failures++; $display("[TB] FAIL async_busy: got %b want 0", sb_busy); end
        checks++; if (ds_ready_go !== 1'b1) begin failures++; $display("[TB] FAIL async_ready_go: got %b want 1", ds_ready_go); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("[TB] FAIL async_sb_err: got %b want 0", sb_err); end
`ifdef DS_HAZARD_PERF_EN
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("[TB] FAIL async_stall_cycles: got %0d want 0", stall_cycles); end
`endif
        #1;
        resetn = 1;
        decode(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_same_cycle();
        test_r0();
        test_drain();
        test_overflow_underflow();
`ifdef DS_HAZARD_PERF_EN
        test_perf();
`endif
        test_async_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
